// File: rtl/fsk_symbol_scheduler.sv
// rtl/fsk_symbol_scheduler.sv - FSK frame scheduler: alternating preamble, then each byte sent as four
// 2-bit symbols MSB pair first, with a one-cycle modulator restart strobe at the start of every symbol.
module fsk_symbol_scheduler #(
  parameter int unsigned SYM_CYCLES    = 64,
  parameter int unsigned PREAMBLE_SYMS = 4,
  parameter logic [1:0]  IDLE_SYM      = 2'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] frame_len,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [1:0] sym_sel,
  output logic       mod_reset_n,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam logic [15:0] LP_TIMER_LAST = 16'(SYM_CYCLES - 1);
  localparam logic [7:0]  LP_PRE_LAST   = 8'(PREAMBLE_SYMS - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_timer;
  logic [7:0]  r_pre_cnt;
  logic [7:0]  r_len;
  logic [7:0]  r_bytes_loaded;
  logic [7:0]  r_bytes_accepted;
  logic [1:0]  r_pair;
  logic [7:0]  r_buf;
  logic [7:0]  r_shift;
  logic        r_buf_full;

  logic w_boundary;
  logic w_start_ok;
  logic w_handshake;
  logic w_load;
  logic w_done;
  logic w_underrun;

  assign w_boundary  = (r_state != S_IDLE) && (r_timer == LP_TIMER_LAST);
  assign w_start_ok  = start && (frame_len != 8'd0);
  assign data_ready  = (r_state != S_IDLE) && !r_buf_full && (r_bytes_accepted < r_len);
  assign w_handshake = data_valid && data_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Frame decisions are only taken on the boundary of the last symbol of a preamble or byte.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_done       = 1'b0;
    w_underrun   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_next = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (w_boundary && (r_pre_cnt == LP_PRE_LAST)) begin
          if (r_buf_full) begin
            w_load       = 1'b1;
            w_state_next = S_DATA;
          end else begin
            w_underrun   = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_boundary && (r_pair == 2'd3)) begin
          if (r_bytes_loaded == r_len) begin
            w_done       = 1'b1;
            w_state_next = S_IDLE;
          end else if (r_buf_full) begin
            w_load = 1'b1;
          end else begin
            w_underrun   = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer          <= 16'd0;
      r_pre_cnt        <= 8'd0;
      r_len            <= 8'd0;
      r_bytes_loaded   <= 8'd0;
      r_bytes_accepted <= 8'd0;
      r_pair           <= 2'd0;
      r_buf            <= 8'd0;
      r_shift          <= 8'd0;
      r_buf_full       <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_timer <= 16'd0;
      if (w_start_ok) begin
        r_len            <= frame_len;
        r_pre_cnt        <= 8'd0;
        r_bytes_loaded   <= 8'd0;
        r_bytes_accepted <= 8'd0;
        r_pair           <= 2'd0;
        r_buf_full       <= 1'b0;
      end
    end else begin
      r_timer <= w_boundary ? 16'd0 : r_timer + 16'd1;
      if (w_handshake) begin
        r_buf            <= data_in;
        r_buf_full       <= 1'b1;
        r_bytes_accepted <= r_bytes_accepted + 8'd1;
      end
      if (w_boundary) begin
        if (r_state == S_PREAMBLE) begin
          r_pre_cnt <= r_pre_cnt + 8'd1;
        end else begin
          r_pair  <= r_pair + 2'd1;
          r_shift <= {r_shift[5:0], 2'b00};
        end
      end
      // A load never coincides with a handshake: the buffer is full for one and empty for the other.
      if (w_load) begin
        r_shift        <= r_buf;
        r_buf_full     <= 1'b0;
        r_bytes_loaded <= r_bytes_loaded + 8'd1;
        r_pair         <= 2'd0;
      end
      if (w_done || w_underrun) begin
        r_buf_full <= 1'b0;
        r_timer    <= 16'd0;
      end
    end
  end

  always_comb begin
    sym_sel = IDLE_SYM;
    case (r_state)
      S_PREAMBLE: sym_sel = r_pre_cnt[0] ? 2'd3 : 2'd0;
      S_DATA:     sym_sel = r_shift[7:6];
      default:    sym_sel = IDLE_SYM;
    endcase
  end

  assign mod_reset_n = !((r_state != S_IDLE) && (r_timer == 16'd0));
  assign busy        = (r_state != S_IDLE);
  assign done        = w_done;
  assign underrun    = w_underrun;

endmodule

// File: tb/tb_fsk_symbol_scheduler.sv
// tb/tb_fsk_symbol_scheduler.sv - self-checking bench: per-cycle frame model plus directed literal checks
module tb_fsk_symbol_scheduler;

  localparam int SYM  = 16;
  localparam int PRE  = 2;
  localparam int PLEN = PRE * SYM;
  localparam int BLEN = 4 * SYM;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] frame_len = 8'd0;
  logic [7:0] data_in = 8'd0;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic [1:0] sym_sel;
  logic       mod_reset_n;
  logic       busy;
  logic       done;
  logic       underrun;

  fsk_symbol_scheduler #(
    .SYM_CYCLES   (SYM),
    .PREAMBLE_SYMS(PRE),
    .IDLE_SYM     (2'd3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .frame_len  (frame_len),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .sym_sel    (sym_sel),
    .mod_reset_n(mod_reset_n),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Frame model: k counts cycles since start was accepted (k=1 is the first preamble cycle).
  bit         m_active = 1'b0;
  int         m_k = 0;
  int         m_len = 0;
  int         m_acc = 0;
  logic [7:0] m_bytes [0:255];

  function automatic int f_loaded();
    int n;
    if (m_k < PLEN + 1) return 0;
    n = (m_k - PLEN - 1) / BLEN + 1;
    return (n < m_len) ? n : m_len;
  endfunction

  function automatic bit f_ready();
    return m_active && (m_acc == f_loaded()) && (m_acc < m_len);
  endfunction

  function automatic bit f_done();
    return m_active && (m_k == PLEN + BLEN * m_len);
  endfunction

  function automatic bit f_under();
    int b;
    if (!m_active || m_k < PLEN || ((m_k - PLEN) % BLEN) != 0) return 1'b0;
    b = (m_k - PLEN) / BLEN;
    return (b < m_len) && (m_acc <= b);
  endfunction

  function automatic logic [1:0] f_sym();
    int idx;
    int j;
    logic [7:0] byte_v;
    if (!m_active) return 2'd3;
    idx = (m_k - 1) / SYM;
    if (idx < PRE) return (idx % 2) ? 2'd3 : 2'd0;
    j = idx - PRE;
    byte_v = m_bytes[8'(j / 4)];
    return 2'((byte_v >> (6 - 2 * (j % 4))) & 8'd3);
  endfunction

  function automatic bit f_mrn();
    return !(m_active && ((m_k - 1) % SYM) == 0);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
    end else if (!m_active) begin
      if (start && frame_len != 8'd0) begin
        m_active <= 1'b1;
        m_k      <= 1;
        m_len    <= int'(frame_len);
        m_acc    <= 0;
      end
    end else begin
      if (f_ready() && data_valid) begin
        m_bytes[8'(m_acc)] <= data_in;
        m_acc              <= m_acc + 1;
      end
      if (f_done() || f_under()) m_active <= 1'b0;
      else m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin : compare_proc
    logic [6:0] act_v;
    logic [6:0] exp_v;
    if (cmp_en) begin
      act_v = {sym_sel, mod_reset_n, data_ready, busy, done, underrun};
      exp_v = {f_sym(), f_mrn(), f_ready(), m_active, f_done(), f_under()};
      n_checks++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL model_cycle t=%0t sym,mrn,rdy,busy,done,und got %b required %b",
                    $time, act_v, exp_v);
    end
  end

  // Byte source: offers queued bytes, pops one per completed handshake.
  logic [7:0] feed_q[$];
  logic       hs;
  initial begin
    forever begin
      @(negedge clk);
      hs = data_valid && data_ready && reset;
      @(posedge clk);
      #2;
      if (hs && feed_q.size() > 0) void'(feed_q.pop_front());
      data_valid = (feed_q.size() > 0);
      data_in    = (feed_q.size() > 0) ? feed_q[0] : 8'h00;
    end
  end

  logic [1:0] rec_sym  [0:299];
  logic       rec_mrn  [0:299];
  logic       rec_rdy  [0:299];
  logic       rec_busy [0:299];
  logic       rec_done [0:299];
  logic       rec_und  [0:299];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  task automatic start_frame(input logic [7:0] len);
    start     = 1'b1;
    frame_len = len;
    tick();
    start     = 1'b0;
    frame_len = 8'd0;
  endtask

  task automatic record(input int k0, input int k1);
    for (int k = k0; k <= k1; k++) begin
      rec_sym[k]  = sym_sel;
      rec_mrn[k]  = mod_reset_n;
      rec_rdy[k]  = data_ready;
      rec_busy[k] = busy;
      rec_done[k] = done;
      rec_und[k]  = underrun;
      if (k < k1) tick();
    end
  endtask

  function automatic int cnt_done(input int k0, input int k1);
    int n = 0;
    for (int k = k0; k <= k1; k++) if (rec_done[k]) n++;
    return n;
  endfunction

  function automatic int cnt_und(input int k0, input int k1);
    int n = 0;
    for (int k = k0; k <= k1; k++) if (rec_und[k]) n++;
    return n;
  endfunction

  int bad;
  int pulses;
  int first_p;
  int last_p;
  int exp_data [0:11] = '{0, 0, 0, 0, 3, 3, 3, 3, 0, 1, 2, 3};

  initial begin
    repeat (3) tick();
    chk("reset_outputs", int'({sym_sel, mod_reset_n, data_ready, busy, done, underrun}), 7'b1110000);
    reset  = 1'b1;
    cmp_en = 1'b1;

    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (sym_sel != 2'd3 || busy || data_ready || !mod_reset_n) bad++;
    end
    chk("idle_50_cycles_bad", bad, 0);

    start = 1'b1;
    frame_len = 8'd0;
    tick();
    start = 1'b0;
    chk("zero_len_start_busy", int'(busy), 0);

    feed_q.push_back(8'hB4);
    start_frame(8'd1);
    record(1, 97);
    chk("b4_sym_k1", rec_sym[1], 0);
    chk("b4_sym_k17", rec_sym[17], 3);
    chk("b4_sym_k33", rec_sym[33], 2);
    chk("b4_sym_k49", rec_sym[49], 3);
    chk("b4_sym_k65", rec_sym[65], 1);
    chk("b4_sym_k81", rec_sym[81], 0);
    chk("b4_done_k96", int'(rec_done[96]), 1);
    chk("b4_done_count", cnt_done(1, 97), 1);
    pulses = 0;
    first_p = 0;
    last_p = 0;
    for (int k = 1; k <= 97; k++) begin
      if (!rec_mrn[k]) begin
        pulses++;
        if (first_p == 0) first_p = k;
        last_p = k;
      end
    end
    chk("b4_mrn_pulses", pulses, 6);
    chk("b4_mrn_first", first_p, 1);
    chk("b4_mrn_last", last_p, 81);
    chk("b4_idle_sym_k97", rec_sym[97], 3);

    feed_q.push_back(8'h00);
    feed_q.push_back(8'hFF);
    feed_q.push_back(8'h1B);
    start_frame(8'd3);
    record(1, 226);
    bad = 0;
    for (int i = 0; i < 12; i++) if (int'(rec_sym[33 + 16 * i]) != exp_data[i]) bad++;
    chk("b2b_data_syms_bad", bad, 0);
    chk("b2b_ready_k97", int'(rec_rdy[97]), 1);
    chk("b2b_ready_k98", int'(rec_rdy[98]), 0);
    chk("b2b_done_k224", int'(rec_done[224]), 1);
    chk("b2b_busy_k225", int'(rec_busy[225]), 0);

    feed_q.push_back(8'hA5);
    start_frame(8'd2);
    record(1, 100);
    chk("under_k96", int'(rec_und[96]), 1);
    chk("under_count", cnt_und(1, 100), 1);
    chk("under_no_done", cnt_done(1, 100), 0);
    chk("under_busy_k97", int'(rec_busy[97]), 0);
    chk("under_sym_k97", rec_sym[97], 3);

    start_frame(8'd1);
    record(1, 34);
    chk("starve_und_k32", int'(rec_und[32]), 1);
    chk("starve_und_count", cnt_und(1, 34), 1);
    chk("starve_busy_k33", int'(rec_busy[33]), 0);

    feed_q.push_back(8'h6C);
    start_frame(8'd1);
    record(1, 39);
    start = 1'b1;
    frame_len = 8'd5;
    tick();
    start = 1'b0;
    frame_len = 8'd0;
    record(40, 98);
    chk("ign_sym_k33", rec_sym[33], 1);
    chk("ign_sym_k65", rec_sym[65], 3);
    chk("ign_done_k96", int'(rec_done[96]), 1);
    chk("ign_busy_k98", int'(rec_busy[98]), 0);

    feed_q.push_back(8'h3C);
    feed_q.push_back(8'hC3);
    start_frame(8'd2);
    record(1, 70);
    reset = 1'b0;
    #1;
    chk("midreset_outputs", int'({sym_sel, mod_reset_n, data_ready, busy, done, underrun}), 7'b1110000);
    repeat (3) tick();
    feed_q.delete();
    reset = 1'b1;
    tick();
    feed_q.push_back(8'h5A);
    start_frame(8'd1);
    record(1, 97);
    chk("after_rst_sym_k33", rec_sym[33], 1);
    chk("after_rst_sym_k65", rec_sym[65], 2);
    chk("after_rst_done_k96", int'(rec_done[96]), 1);
    chk("after_rst_busy_k97", int'(rec_busy[97]), 0);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fsk_symbol_scheduler.md
FSK_SYMBOL_SCHEDULER -- requirements
Module: fsk_symbol_scheduler

Interface
REQ-001 SHALL have parameter SYM_CYCLES, default 64: clk cycles per symbol; legal range 16..65535.
REQ-002 SHALL have parameter PREAMBLE_SYMS, default 4: preamble symbols per frame; legal range 1..255.
REQ-003 SHALL have parameter IDLE_SYM, default 2'd3: frequency select driven while idle.
REQ-004 SHALL have port clk, input, 1: single rising-edge clock, also the modulator clock.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: frame start request, sampled on clk.
REQ-007 SHALL have port frame_len, input, 8: payload bytes, sampled with start; 0 is illegal.
REQ-008 SHALL have port data_in, input, 8: payload byte.
REQ-009 SHALL have port data_valid, input, 1: data_in is valid.
REQ-010 SHALL have port data_ready, output, 1: scheduler accepts a byte this cycle.
REQ-011 SHALL have port sym_sel, output, 2: symbol driven to the modulator select input.
REQ-012 SHALL have port mod_reset_n, output, 1: active-low restart of the modulator dividers.
REQ-013 SHALL have port busy, output, 1: frame in progress.
REQ-014 SHALL have port done, output, 1: one-cycle pulse on normal frame completion.
REQ-015 SHALL have port underrun, output, 1: one-cycle pulse on frame abort caused by data starvation.

Function
REQ-016 SHALL implement states IDLE, PREAMBLE and DATA.
REQ-017 IDLE: start=1 and frame_len!=0 -> PREAMBLE on the next edge, latching frame_len; start while busy, or with frame_len=0, SHALL be ignored.
REQ-018 A symbol timer SHALL count 0..SYM_CYCLES-1; a symbol boundary is the cycle in which the timer equals SYM_CYCLES-1.
REQ-019 The timer SHALL clear to 0 on entry to PREAMBLE and at every boundary.
REQ-020 mod_reset_n SHALL be 0 for exactly the first cycle (timer=0) of every symbol and 1 otherwise, including in IDLE.
REQ-021 PREAMBLE sym_sel sequence SHALL be 0,3,0,3,... for PREAMBLE_SYMS symbols; sym_sel=0 in the cycle after start is accepted.
REQ-022 At the last preamble boundary: holding buffer full -> DATA, and the buffer moves into the shift register; buffer empty -> underrun.
REQ-023 DATA: each byte SHALL be sent as 4 symbols, MSB pair first: [7:6], [5:4], [3:2], [1:0].
REQ-024 At the boundary of symbol [1:0], if bytes remain: buffer full -> load the next byte; buffer empty -> underrun.
REQ-025 At the boundary of symbol [1:0] of the last byte SHALL return to IDLE and pulse done=1 in that same cycle.
REQ-026 An 8-bit holding buffer SHALL accept data_in when data_valid=1 and data_ready=1 at a clk edge.
REQ-027 data_ready SHALL equal (state!=IDLE) AND buffer empty AND bytes_accepted<frame_len, decoded from registers only.
REQ-028 A handshake and a buffer-to-shift-register transfer in the same cycle is impossible by REQ-027.
REQ-029 Underrun SHALL:
  - pulse underrun=1 for one cycle;
  - go to IDLE;
  - discard buffered data;
  - leave done=0.
REQ-030 busy SHALL be 1 in PREAMBLE and DATA and 0 in IDLE.
REQ-031 In IDLE, sym_sel SHALL equal IDLE_SYM.
REQ-032 All outputs SHALL be registered or decoded from registers only, with no combinational path from inputs.
REQ-033 Byte counters SHALL be 8-bit with no wrap, since frame_len is at most 255.

Reset
REQ-034 reset=0 SHALL asynchronously force:
  - state=IDLE, timer=0, counters=0, buffer empty;
  - sym_sel=IDLE_SYM, mod_reset_n=1;
  - data_ready=0, busy=0, done=0, underrun=0.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no done or underrun pulse; operation resumes on the first edge after release.

Verification (SYM_CYCLES=16, PREAMBLE_SYMS=2)
REQ-036 Reset idle: release reset, hold for 50 cycles -> sym_sel=3, busy=0, data_ready=0, mod_reset_n=1 throughout.
REQ-037 One-byte frame:
  - stimulus: start with frame_len=1, byte 8'hB4 offered immediately;
  - response: sym_sel=0,3 (16 cycles each), then 2,3,1,0 (16 cycles each);
  - done pulses in cycle 96 after start; 6 mod_reset_n pulses, 16 cycles apart.
REQ-038 Back-to-back frame:
  - stimulus: frame_len=3, bytes 8'h00, 8'hFF, 8'h1B, valid held high;
  - response: 12 data symbols 0000 3333 0123, no gaps;
  - data_ready drops after the third handshake.
REQ-039 Underrun:
  - stimulus: frame_len=2, only the first byte supplied;
  - response: underrun pulses at the 4th data boundary, then busy=0, sym_sel=3, done never asserted.
REQ-040 Starved preamble and ignored start:
  - stimulus: frame_len=1 with no data; separately, start pulsed during DATA;
  - response: underrun at cycle 32 for the first; the second start has no effect on the running frame or on frame_len.
REQ-041 Mid-frame reset:
  - stimulus: reset=0 asserted in DATA symbol 2 for 3 cycles;
  - response: outputs take reset values immediately with no done pulse; a new start then runs a correct frame.
